// File: rtl/pulse_train_decoder.sv
// Decodes a single-bit pulse train into (pulses per set - 1) and (sets - 1),
// with one-cycle valid/error strobes. All outputs come straight from flops.
module pulse_train_decoder #(
  parameter int END_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [2:0] pulses_out,
  output logic [2:0] sets_out,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int LW = $clog2(END_GAP + 1);
  localparam logic [LW-1:0] GAP_L = LW'(END_GAP);
  localparam logic [LW-1:0] RUN_ONE = LW'(1);
  localparam logic [LW-1:0] RUN_SET = LW'(3);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HI   = 2'd2,
    S_LO   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    hi_cnt_q, hi_cnt_d;
  logic [3:0]    ref_cnt_q, ref_cnt_d;
  logic [3:0]    set_cnt_q, set_cnt_d;
  logic [LW-1:0] low_run_q, low_run_d;
  logic [2:0]    pulses_q, pulses_d;
  logic [2:0]    sets_q, sets_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  logic          first_set_s;
  logic          close_bad_s;
  logic [3:0]    set_inc_s;
  logic [3:0]    hi_inc_s;
  logic [3:0]    ref_new_s;
  logic [LW-1:0] low_inc_s;

  // Set-close bookkeeping shared by the end-of-set and end-of-train paths.
  always_comb begin
    first_set_s = (set_cnt_q == 4'd0);
    set_inc_s   = set_cnt_q + 4'd1;
    hi_inc_s    = hi_cnt_q + 4'd1;
    ref_new_s   = first_set_s ? hi_cnt_q : ref_cnt_q;
    close_bad_s = (!first_set_s && (hi_cnt_q != ref_cnt_q)) || (set_inc_s == 4'd9);
    if (low_run_q == GAP_L) begin
      low_inc_s = GAP_L;
    end else begin
      low_inc_s = low_run_q + RUN_ONE;
    end
  end

  // Next-state and counter updates; strobes default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    ref_cnt_d = ref_cnt_q;
    set_cnt_d = set_cnt_q;
    low_run_d = low_run_q;
    pulses_d  = pulses_q;
    sets_d    = sets_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    if (enable) begin
      low_run_d = pulse_in ? '0 : low_inc_s;
      case (state_q)
        S_SYNC: begin
          if (!pulse_in && (low_inc_s == GAP_L)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_IDLE: begin
          if (pulse_in) begin
            hi_cnt_d  = 4'd1;
            set_cnt_d = 4'd0;
            state_d   = S_HI;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HI: begin
          if (pulse_in) begin
            error_d = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_LO;
          end
        end
        S_LO: begin
          if (!pulse_in) begin
            if (low_inc_s == GAP_L) begin
              if (close_bad_s) begin
                error_d = 1'b1;
                state_d = S_SYNC;
              end else begin
                ref_cnt_d = ref_new_s;
                set_cnt_d = set_inc_s;
                pulses_d  = ref_new_s[2:0] - 3'd1;
                sets_d    = set_cnt_q[2:0];
                valid_d   = 1'b1;
                state_d   = S_IDLE;
              end
            end else begin
              state_d = S_LO;
            end
          end else if (low_run_q == RUN_ONE) begin
            if (hi_inc_s == 4'd9) begin
              error_d = 1'b1;
              state_d = S_SYNC;
            end else begin
              hi_cnt_d = hi_inc_s;
              state_d  = S_HI;
            end
          end else if (low_run_q == RUN_SET) begin
            if (close_bad_s) begin
              error_d = 1'b1;
              state_d = S_SYNC;
            end else begin
              ref_cnt_d = ref_new_s;
              set_cnt_d = set_inc_s;
              hi_cnt_d  = 4'd1;
              state_d   = S_HI;
            end
          end else begin
            error_d = 1'b1;
            state_d = S_SYNC;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == S_HI) || (state_d == S_LO);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SYNC;
      hi_cnt_q  <= 4'd0;
      ref_cnt_q <= 4'd0;
      set_cnt_q <= 4'd0;
      low_run_q <= '0;
      pulses_q  <= 3'd0;
      sets_q    <= 3'd0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      ref_cnt_q <= ref_cnt_d;
      set_cnt_q <= set_cnt_d;
      low_run_q <= low_run_d;
      pulses_q  <= pulses_d;
      sets_q    <= sets_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign pulses_out = pulses_q;
  assign sets_out   = sets_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_train_decoder.sv
// Self-checking bench: directed vector table, reset/enable sequences, loopback
// sweep and randomized trains judged by a set-size rule model.
module tb_pulse_train_decoder;

  localparam int END_GAP = 4;
  localparam int FLUSH   = 2 * END_GAP + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pulse_in;
  logic [2:0] pulses_out;
  logic [2:0] sets_out;
  logic       valid;
  logic       error;
  logic       busy;

  pulse_train_decoder #(.END_GAP(END_GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
    .pulses_out(pulses_out), .sets_out(sets_out),
    .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_en_cyc = 0;
  int valid_cnt, err_cnt, last_valid_cyc, dec_cyc, strobe_busy;
  int stall_pct = 0;
  bit toggle_en = 1'b0;
  int exp_p, exp_s;
  int sizes_q[$];

  typedef struct {
    string pat;
    int    nv;
    int    ne;
    int    ep;
    int    es;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic p, input logic en);
    pulse_in = p;
    enable   = en;
    @(posedge clk);
    #1;
    cyc++;
    if (en) last_en_cyc = cyc;
    if (valid || error) begin
      chk("strobe_exclusive", int'(valid & error), 0);
      strobe_busy = strobe_busy | int'(busy);
    end
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (error) err_cnt++;
  endtask

  task automatic sample(input logic p);
    if (toggle_en) begin
      cycle(p, 1'b1);
      cycle(p, 1'b0);
    end else begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(99) < stall_pct) cycle(1'($urandom_range(1)), 1'b0);
      cycle(p, 1'b1);
    end
  endtask

  task automatic clear_obs();
    valid_cnt = 0;
    err_cnt = 0;
    last_valid_cyc = -1;
    strobe_busy = 0;
  endtask

  task automatic run_pattern(input string pat, input bit flush, input bit chk_busy);
    logic b;
    for (int i = 0; i < pat.len(); i++) begin
      b = (pat.getc(i) == 8'd72);
      sample(b);
      if (i == 0 && chk_busy) chk("busy_rise", int'(busy), 1);
    end
    dec_cyc = last_en_cyc;
    if (flush) repeat (FLUSH) sample(1'b0);
  endtask

  // Line image of the sets listed in sizes_q: 1 low inside a set, 3 between, END_GAP at the end.
  function automatic string build_str();
    string s = "";
    for (int i = 0; i < sizes_q.size(); i++) begin
      for (int k = 0; k < sizes_q[i]; k++) begin
        s = {s, "H"};
        if (k < sizes_q[i] - 1) s = {s, "L"};
      end
      if (i < sizes_q.size() - 1) s = {s, "LLL"};
      else for (int g = 0; g < END_GAP; g++) s = {s, "L"};
    end
    return s;
  endfunction

  function automatic string gen_str(input int p, input int n);
    sizes_q.delete();
    for (int i = 0; i < n; i++) sizes_q.push_back(p);
    return build_str();
  endfunction

  task automatic check_train(input string tag, input int nv, input int ne, input int ep, input int es);
    chk({tag, "_valid_cnt"}, valid_cnt, nv);
    chk({tag, "_error_cnt"}, err_cnt, ne);
    chk({tag, "_pulses"}, int'(pulses_out), ep);
    chk({tag, "_sets"}, int'(sets_out), es);
    chk({tag, "_busy_at_strobe"}, strobe_busy, 0);
    if (nv > 0) chk({tag, "_valid_latency"}, last_valid_cyc, dec_cyc);
  endtask

  initial begin
    tbl[0] = '{"HLHLHLLLHLHLHLLLL", 1, 0, 2, 1};
    tbl[1] = '{"HLLLL", 1, 0, 0, 0};
    tbl[2] = '{gen_str(8, 8), 1, 0, 7, 7};
    tbl[3] = '{gen_str(9, 1), 0, 1, 7, 7};
    tbl[4] = '{"HHLLLL", 0, 1, 7, 7};
    tbl[5] = '{"HLLHLLLL", 0, 1, 7, 7};
    tbl[6] = '{"HLHLHLLLHLHLLLL", 0, 1, 7, 7};
    tbl[7] = '{"HLLLLHLHLLLL", 2, 0, 1, 0};
    tbl[8] = '{gen_str(1, 9), 0, 1, 1, 0};

    // Reset with enable and a high line: reset must win.
    clear_obs();
    reset = 1'b1;
    repeat (3) cycle(1'b1, 1'b1);
    chk("reset_valid", int'(valid), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'(pulses_out), 0);
    chk("reset_sets", int'(sets_out), 0);
    reset = 1'b0;
    repeat (FLUSH) sample(1'b0);

    for (int i = 0; i < 9; i++) begin
      clear_obs();
      run_pattern(tbl[i].pat, 1'b1, 1'b1);
      check_train($sformatf("vec%0d", i), tbl[i].nv, tbl[i].ne, tbl[i].ep, tbl[i].es);
    end

    // Reset during the second set, released while the line keeps toggling.
    clear_obs();
    run_pattern("HLHLHLLLHL", 1'b0, 1'b0);
    reset = 1'b1;
    cycle(1'b1, 1'b1);
    reset = 1'b0;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_pulses", int'(pulses_out), 0);
    run_pattern("LHLHLLLHLH", 1'b0, 1'b0);
    chk("midreset_no_strobe", valid_cnt + err_cnt, 0);
    clear_obs();
    run_pattern({"LLLL", gen_str(2, 1)}, 1'b1, 1'b0);
    check_train("after_reset", 1, 0, 1, 0);

    // Half-rate train with enable toggling every cycle.
    toggle_en = 1'b1;
    clear_obs();
    run_pattern(tbl[0].pat, 1'b1, 1'b1);
    check_train("enable_toggle", 1, 0, 2, 1);
    toggle_en = 1'b0;

    // Loopback sweep of generator settings with random enable stalls.
    stall_pct = 30;
    foreach (tbl[j]) begin end
    for (int pi = 0; pi < 3; pi++) begin
      for (int si = 0; si < 3; si++) begin
        exp_p = (pi == 0) ? 0 : ((pi == 1) ? 3 : 7);
        exp_s = (si == 0) ? 0 : ((si == 1) ? 2 : 7);
        clear_obs();
        run_pattern(gen_str(exp_p + 1, exp_s + 1), 1'b1, 1'b1);
        check_train($sformatf("loop_p%0d_s%0d", exp_p, exp_s), 1, 0, exp_p, exp_s);
      end
    end

    // Random trains: good iff every set has the same size, at most 8 highs and 8 sets.
    for (int t = 0; t < 40; t++) begin
      int kind, p, n, q;
      bit good;
      kind = $urandom_range(3);
      p = $urandom_range(1, 8);
      n = $urandom_range(1, 8);
      if (kind == 3) n = 9;
      if (kind == 1 && n < 2) n = 2;
      sizes_q.delete();
      for (int i = 0; i < n; i++) sizes_q.push_back(p);
      if (kind == 1) begin
        q = 1 + ((p - 1 + $urandom_range(1, 7)) % 8);
        sizes_q[$urandom_range(1, n - 1)] = q;
      end else if (kind == 2) begin
        sizes_q[$urandom_range(0, n - 1)] = 9;
      end
      good = (sizes_q.size() <= 8);
      foreach (sizes_q[k]) if (sizes_q[k] != sizes_q[0] || sizes_q[k] > 8) good = 1'b0;
      if (good) begin
        exp_p = sizes_q[0] - 1;
        exp_s = sizes_q.size() - 1;
      end
      clear_obs();
      run_pattern(build_str(), 1'b1, 1'b1);
      check_train($sformatf("rand%0d_k%0d", t, kind), good ? 1 : 0, good ? 0 : 1, exp_p, exp_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
